// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle instruction sequencer for the RV64 datapath
module multicycle_ctrl_fsm #(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             illegal,
   output logic             timeout,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam int              WC_W      = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef struct packed {
      logic       imem_req;
      logic       pc_write;
      logic       br_exec;
      logic       st_mem;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_op;
   } strobe_t;

   state_t          state_q, state_d;
   logic [6:0]      op_q, op_d;
   logic [WC_W-1:0] wait_q, wait_d;
   logic            illegal_d, timeout_d, retire;
   strobe_t         strobe_q;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
   endfunction

   // Strobes of the state being entered, so every Moore output comes straight from a flop.
   function automatic strobe_t strobes_for(input state_t s, input logic [6:0] op);
      strobe_t st;
      logic    ld_st;
      ld_st = (op == OP_LD) || (op == OP_ST);
      st    = '0;
      if (s == S_EXEC || s == S_MEM || s == S_WB) begin
         st.alu_src = (op == OP_I) || ld_st;
         st.alu_op  = (op == OP_BR) ? 2'b01 : (ld_st ? 2'b00 : 2'b10);
      end
      case (s)
         S_FETCH: st.imem_req = 1'b1;
         S_EXEC: begin
            st.pc_write = (op == OP_BR);
            st.br_exec  = (op == OP_BR);
         end
         S_MEM: begin
            st.mem_read  = (op == OP_LD);
            st.mem_write = (op == OP_ST);
            st.st_mem    = (op == OP_ST);
         end
         S_WB: begin
            st.reg_write  = 1'b1;
            st.mem_to_reg = (op == OP_LD);
            st.pc_write   = 1'b1;
         end
         default: st.imem_req = 1'b0;
      endcase
      return st;
   endfunction

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      wait_d    = wait_q;
      illegal_d = illegal;
      timeout_d = timeout;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (is_legal(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            wait_d = '0;
            if (op_q == OP_BR) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (op_q == OP_LD || op_q == OP_ST) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               wait_d = '0;
               if (op_q == OP_ST) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         op_q     <= '0;
         wait_q   <= '0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
         instret  <= '0;
         strobe_q <= strobes_for(S_FETCH, 7'd0);
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         wait_q   <= wait_d;
         illegal  <= illegal_d;
         timeout  <= timeout_d;
         strobe_q <= strobes_for(state_d, op_d);
         if (retire) instret <= instret + 1'b1;
      end
   end

   // Gating with reset keeps an aborted instruction from committing anything while reset is low.
   assign state    = state_q;
   assign imem_req = reset & strobe_q.imem_req;
   assign ir_write = reset & strobe_q.imem_req & imem_ready;
   assign pc_write = reset & (strobe_q.pc_write | (strobe_q.st_mem & dmem_ready));
   assign pc_src   = reset & strobe_q.br_exec & zero;
   assign RegWrite = reset & strobe_q.reg_write;
   assign MemRead  = reset & strobe_q.mem_read;
   assign MemWrite = reset & strobe_q.mem_write;
   assign MemtoReg = reset & strobe_q.mem_to_reg;
   assign ALUSrc   = reset & strobe_q.alu_src;
   assign ALUOp    = {2{reset}} & strobe_q.alu_op;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

   localparam int CNT_W   = 64;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [6:0]       opcode;
   logic             zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req, ir_write, pc_write, pc_src;
   logic             RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc;
   logic [1:0]       ALUOp;
   logic             illegal, timeout;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   multicycle_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout),
      .state(state), .instret(instret)
   );

   always #10 clk = ~clk;

   typedef struct {
      int          cls;
      int          lat;
      int          nreg;
      int          nmr;
      int          nmw;
      logic        pcsrc;
      logic        m2r;
      logic        alusrc;
      logic [1:0]  aluop;
      logic [63:0] instret;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          di, dd, fcnt, dcnt;
   logic [63:0] model_instret;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] op_of(input int c);
      case (c)
         0:       return 7'b0110011;
         1:       return 7'b0010011;
         2:       return 7'b0000011;
         3:       return 7'b0100011;
         default: return 7'b1100011;
      endcase
   endfunction

   // Monitor: accumulates strobe activity per instruction and compares at every retire.
   int          m_cyc = 0, m_reg = 0, m_mr = 0, m_mw = 0;
   logic        m_m2r = 1'b0, m_overlap = 1'b0, m_pend = 1'b0;
   logic [63:0] m_pend_instret;
   exp_t        m_e;

   always begin
      @(negedge clk);
      #5;
      if (m_pend) begin
         check("instret_after_retire", longint'(instret), longint'(m_pend_instret));
         m_pend = 1'b0;
      end
      if (!reset) begin
         m_cyc = 0; m_reg = 0; m_mr = 0; m_mw = 0; m_m2r = 1'b0; m_overlap = 1'b0;
      end else begin
         m_cyc++;
         m_reg += int'(RegWrite);
         m_mr  += int'(MemRead);
         m_mw  += int'(MemWrite);
         if (RegWrite) m_m2r = MemtoReg;
         if ((RegWrite && MemWrite) || (MemRead && MemWrite)) m_overlap = 1'b1;
         if (pc_write) begin
            if (sb.size() == 0) begin
               check("unexpected_retire", 1, 0);
            end else begin
               m_e = sb.pop_front();
               check($sformatf("latency_cls%0d", m_e.cls), m_cyc, m_e.lat);
               check($sformatf("pc_src_cls%0d", m_e.cls), longint'(pc_src), longint'(m_e.pcsrc));
               check($sformatf("regwrite_cycles_cls%0d", m_e.cls), m_reg, m_e.nreg);
               check($sformatf("memread_cycles_cls%0d", m_e.cls), m_mr, m_e.nmr);
               check($sformatf("memwrite_cycles_cls%0d", m_e.cls), m_mw, m_e.nmw);
               check($sformatf("memtoreg_cls%0d", m_e.cls), longint'(m_m2r), longint'(m_e.m2r));
               check($sformatf("alusrc_cls%0d", m_e.cls), longint'(ALUSrc), longint'(m_e.alusrc));
               check($sformatf("aluop_cls%0d", m_e.cls), longint'(ALUOp), longint'(m_e.aluop));
               check("strobe_overlap", longint'(m_overlap), 0);
               m_pend         = 1'b1;
               m_pend_instret = m_e.instret;
            end
            m_cyc = 0; m_reg = 0; m_mr = 0; m_mw = 0; m_m2r = 1'b0; m_overlap = 1'b0;
         end
      end
   end

   // One clock of memory behaviour: ready after the chosen number of wait cycles.
   task automatic step(output logic retired);
      imem_ready = imem_req && (fcnt >= di);
      if (imem_req) fcnt++; else fcnt = 0;
      dmem_ready = (MemRead || MemWrite) && (dcnt >= dd);
      if (MemRead || MemWrite) dcnt++; else dcnt = 0;
      #1;
      retired = pc_write;
      @(negedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      logic r;
      for (int k = 0; k < n; k++) step(r);
   endtask

   task automatic do_reset();
      reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_state", longint'(state), 0);
      check("rst_instret", longint'(instret), 0);
      check("rst_illegal", longint'(illegal), 0);
      check("rst_timeout", longint'(timeout), 0);
      check("rst_strobes", longint'({imem_req, pc_write, RegWrite, MemRead, MemWrite}), 0);
      model_instret = '0; fcnt = 0; dcnt = 0;
      reset = 1'b1;
      #1;
   endtask

   task automatic run_instr(input int c, input int fdel, input int ddel, input logic z);
      exp_t e;
      logic r;
      di = fdel; dd = ddel; opcode = op_of(c); zero = z;
      e.cls = c; e.nreg = 0; e.nmr = 0; e.nmw = 0; e.pcsrc = 1'b0; e.m2r = 1'b0;
      case (c)
         0, 1: begin e.lat = 4 + fdel; e.nreg = 1; e.alusrc = (c == 1); e.aluop = 2'b10; end
         2: begin e.lat = 5 + fdel + ddel; e.nreg = 1; e.nmr = ddel + 1; e.m2r = 1'b1;
                  e.alusrc = 1'b1; e.aluop = 2'b00; end
         3: begin e.lat = 4 + fdel + ddel; e.nmw = ddel + 1; e.alusrc = 1'b1; e.aluop = 2'b00; end
         default: begin e.lat = 3 + fdel; e.pcsrc = z; e.alusrc = 1'b0; e.aluop = 2'b01; end
      endcase
      model_instret = model_instret + 64'd1;
      e.instret     = model_instret;
      sb.push_back(e);
      r = 1'b0;
      for (int k = 0; k < 200 && !r; k++) step(r);
      if (!r) check($sformatf("retire_wait_cls%0d", c), 0, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      opcode = 7'd0; zero = 1'b0; di = 0; dd = 0; fcnt = 0; dcnt = 0;
      do_reset();

      run_instr(0, 0, 0, 1'b0);
      run_instr(2, 0, 3, 1'b0);
      run_instr(4, 0, 0, 1'b1);
      run_instr(4, 0, 0, 1'b0);
      run_instr(3, 0, 0, 1'b1);
      run_instr(1, TIMEOUT - 1, 0, 1'b0);
      run_instr(2, 0, TIMEOUT - 1, 1'b0);
      for (int n = 0; n < 40; n++) begin
         run_instr(int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
                   1'($urandom_range(0, 1)));
      end

      // Illegal opcode traps after DECODE and stays there.
      do_reset();
      di = 0; dd = 0; opcode = 7'b1111111;
      steps(2);
      check("illegal_trap_state", longint'(state), 5);
      check("illegal_flag", longint'(illegal), 1);
      steps(5);
      check("illegal_sticky_state", longint'(state), 5);
      check("illegal_no_regwrite", longint'({RegWrite, pc_write}), 0);

      // imem never ready: trap on the TIMEOUT-th wait cycle, not before.
      do_reset();
      di = 1000; opcode = op_of(0);
      steps(TIMEOUT - 1);
      check("fetch_wait_state", longint'(state), 0);
      check("fetch_wait_timeout", longint'(timeout), 0);
      steps(1);
      check("fetch_timeout_state", longint'(state), 5);
      check("fetch_timeout_flag", longint'(timeout), 1);

      // dmem never ready on a load.
      do_reset();
      di = 0; dd = 1000; opcode = op_of(2);
      steps(3 + TIMEOUT - 1);
      check("mem_wait_state", longint'(state), 3);
      check("mem_wait_memread", longint'(MemRead), 1);
      steps(1);
      check("mem_timeout_state", longint'(state), 5);
      check("mem_timeout_flag", longint'(timeout), 1);
      check("mem_timeout_memread", longint'(MemRead), 0);

      // Reset in the middle of a store's memory wait.
      do_reset();
      run_instr(0, 0, 0, 1'b0);
      run_instr(1, 0, 0, 1'b0);
      di = 0; dd = 1000; opcode = op_of(3);
      steps(4);
      check("st_wait_memwrite", longint'(MemWrite), 1);
      reset = 1'b0;
      #1;
      check("st_abort_pcwrite", longint'({pc_write, MemWrite}), 0);
      @(posedge clk);
      #1;
      check("st_abort_memwrite", longint'(MemWrite), 0);
      check("st_abort_state", longint'(state), 0);
      check("st_abort_instret", longint'(instret), 0);
      model_instret = '0; fcnt = 0; dcnt = 0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      run_instr(0, 0, 0, 1'b0);
      run_instr(4, 1, 0, 1'b1);

      steps(2);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
